reg_file_pointer_sequencer: RTL
===============================

# reg_file_pointer_sequencer

Multi-cycle controller that owns both register-file ports for the duration of an X/Y/Z pointer access. It reads the 16-bit pointer pair, produces the effective data-memory address, and writes back the post-incremented or pre-decremented pointer. It sits between the decode/control unit and the register file, alongside the normal operand path. Optionally, it also arbitrates a single-register debug read port onto the same register-file ports.

## Interface
- DATA_WIDTH, 8, register width
- R_ADDR_WIDTH, 5, register address width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req  in  1  start pointer operation; accepted only when ready=1
- req_ptr  in  2  pointer select: 0=X, 1=Y, 2=Z, 3=illegal
- req_mode  in  2  0=plain, 1=post-increment, 2=pre-decrement, 3=illegal
- ready  out  1  sequencer idle, request can be accepted
- done  out  1  one-cycle pulse: operation finished
- err  out  1  one-cycle pulse: illegal req_ptr/req_mode, request dropped
- addr_out  out  16  effective address, valid while addr_valid=1
- addr_valid  out  1  addr_out valid (same cycle as done)
- rd_addr, rr_addr  out  R_ADDR_WIDTH  register-file port addresses (low / high byte)
- rd_cs, rr_cs, rd_we, rr_we, rd_oe, rr_oe  out  1 each  port strobes
- rd_wdata, rr_wdata  out  DATA_WIDTH  write data (low / high byte)
- rd_rdata, rr_rdata  in  DATA_WIDTH  read data, valid in the cycle oe=1

## Operation
- States: IDLE, READ, UPDATE.
- IDLE: ready=1, all port strobes 0.
  - req=1 with legal codes: latch ptr/mode and go to READ.
  - Illegal ptr or mode: err=1 for the following cycle, stay in IDLE.
- READ: rd_addr=XL/YL/ZL (26/28/30) and rr_addr=XH/YH/ZH (27/29/31); cs=1, oe=1, we=0 on both ports. At the clock edge, capture {rr_rdata, rd_rdata} into ptr_q, then go to UPDATE.
- UPDATE: done=1 and addr_valid=1, then return to IDLE.
  - plain: addr_out=ptr_q; no write.
  - post-increment: addr_out=ptr_q; write ptr_q+1.
  - pre-decrement: addr_out=ptr_q-1; write ptr_q-1.
  - Write: same addresses as READ, cs=1, we=1, oe=0, rd_wdata=new[7:0], rr_wdata=new[15:8].
- Arithmetic is modulo 2^16: 0xFFFF+1=0x0000, 0x0000-1=0xFFFF. The carry between bytes is internal; no flags are produced.
- req is ignored while ready=0; it is not queued.
- When no strobe is active, addresses and write data are driven to 0.

## Timing
- Reset (asynchronous): state=IDLE, ptr_q=0. Outputs: ready=1; done, err, addr_valid, addr_out, and all strobes/addresses/wdata 0.
- Request accepted at edge k: READ in cycle k+1, UPDATE (done) in cycle k+2, ready=1 again in cycle k+3. Throughput is one operation per 3 cycles.
- err is asserted in the cycle after the illegal request; ready stays 1.
- Reset asserted during READ or UPDATE aborts immediately. A partially issued write completes only if its clock edge occurred before reset; the pointer is never half-written because both bytes are written on the same edge.

## Configuration
- `RF_SEQ_DEBUG_PORT_EN` defined: adds ports dbg_req (in 1), dbg_addr (in R_ADDR_WIDTH), dbg_rdata (out DATA_WIDTH), dbg_valid (out 1).
  - Granted only in IDLE when req=0, so the pointer request always wins.
  - Grant causes one DBG state cycle: rd port reads dbg_addr (cs=1, oe=1); ready=0 during DBG.
  - Next cycle: dbg_valid=1 for one cycle with dbg_rdata=captured value. dbg_req held through contention is served once IDLE is free.
  - Reset values: dbg_valid=0, dbg_rdata=0.
- Undefined: no debug ports, no DBG state; behaviour is exactly as above.

## Structure
- defines.vh holds:
  - XL..ZH register numbers
  - PTR_X/PTR_Y/PTR_Z codes
  - MODE_PLAIN/MODE_POSTINC/MODE_PREDEC codes
  - state encodings
- The decoder maps TYPE_LD_*/TYPE_ST_* opcode types to these ptr/mode codes.
- One sub-module, pointer_incdec: combinational 16-bit ±1 with mode select. It outputs the new pointer and the effective address.

## Test plan
- Y=0x1234 preloaded; req ptr=Y, mode=plain -> READ on addresses 28/29; addr_out=0x1234 with done in cycle k+2; no write strobe.
- X=0x00FF; post-increment -> addr_out=0x00FF; write rd_wdata=0x00 to reg 26 and rr_wdata=0x01 to reg 27 in the same cycle.
- Z=0x0000; pre-decrement -> addr_out=0xFFFF; regs 30/31 written 0xFF/0xFF.
- req_ptr=3 or req_mode=3 -> err pulse one cycle later; no strobes; ready stays 1.
- Second req during READ/UPDATE -> ignored. Reset asserted in UPDATE -> all outputs 0 asynchronously and ready=1.
- (RF_SEQ_DEBUG_PORT_EN) dbg_req and req in the same IDLE cycle -> pointer operation first; dbg_valid follows after ready returns, with dbg_rdata equal to the dbg_addr contents.

Source files
------------

// File: rtl/reg_file_pointer_sequencer_pkg.sv
// Shared constants for the X/Y/Z pointer sequencer: register numbers, pointer/mode codes, states.
// Optional debug read port is enabled with RF_SEQ_DEBUG_PORT_EN.
package reg_file_pointer_sequencer_pkg;

    localparam int XL = 26;
    localparam int XH = 27;
    localparam int YL = 28;
    localparam int YH = 29;
    localparam int ZL = 30;
    localparam int ZH = 31;

    localparam logic [1:0] PTR_X = 2'd0;
    localparam logic [1:0] PTR_Y = 2'd1;
    localparam logic [1:0] PTR_Z = 2'd2;

    localparam logic [1:0] MODE_PLAIN   = 2'd0;
    localparam logic [1:0] MODE_POSTINC = 2'd1;
    localparam logic [1:0] MODE_PREDEC  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_UPDATE = 2'd2,
        ST_DBG    = 2'd3
    } state_e;

    // Low-byte register of a pointer pair; the high byte is always the next register.
    function automatic int lo_reg(input logic [1:0] ptr);
        case (ptr)
            PTR_Y:   return YL;
            PTR_Z:   return ZL;
            default: return XL;
        endcase
    endfunction

endpackage

// File: rtl/reg_file_pointer_sequencer_incdec.sv
// Combinational 16-bit pointer adjust: new pointer value and effective address per access mode.
module pointer_incdec
    import reg_file_pointer_sequencer_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] ptr,
    input  logic [1:0]   mode,
    output logic [W-1:0] new_ptr,
    output logic [W-1:0] eff_addr
);

    localparam logic [W-1:0] ONE = W'(1);

    always_comb begin
        new_ptr  = ptr;
        eff_addr = ptr;
        case (mode)
            MODE_POSTINC: new_ptr = ptr + ONE;
            MODE_PREDEC: begin
                new_ptr  = ptr - ONE;
                eff_addr = ptr - ONE;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/reg_file_pointer_sequencer.sv
// Owns both register-file ports for an X/Y/Z pointer read / address / write-back sequence.
// Define RF_SEQ_DEBUG_PORT_EN to add a single-register debug read port arbitrated onto the rd port.
module reg_file_pointer_sequencer
    import reg_file_pointer_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int R_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req,
    input  logic [1:0]                req_ptr,
    input  logic [1:0]                req_mode,
    output logic                      ready,
    output logic                      done,
    output logic                      err,
    output logic [2*DATA_WIDTH-1:0]   addr_out,
    output logic                      addr_valid,
    output logic [R_ADDR_WIDTH-1:0]   rd_addr,
    output logic [R_ADDR_WIDTH-1:0]   rr_addr,
    output logic                      rd_cs,
    output logic                      rr_cs,
    output logic                      rd_we,
    output logic                      rr_we,
    output logic                      rd_oe,
    output logic                      rr_oe,
    output logic [DATA_WIDTH-1:0]     rd_wdata,
    output logic [DATA_WIDTH-1:0]     rr_wdata,
    input  logic [DATA_WIDTH-1:0]     rd_rdata,
    input  logic [DATA_WIDTH-1:0]     rr_rdata
`ifdef RF_SEQ_DEBUG_PORT_EN
    ,
    input  logic                      dbg_req,
    input  logic [R_ADDR_WIDTH-1:0]   dbg_addr,
    output logic [DATA_WIDTH-1:0]     dbg_rdata,
    output logic                      dbg_valid
`endif
);

    localparam int PW = 2 * DATA_WIDTH;

    state_e                  state_q, state_d;
    logic [1:0]              ptr_sel_q, ptr_sel_d;
    logic [1:0]              mode_q, mode_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic                    ready_q, ready_d, done_q, done_d, err_q, err_d;
    logic [PW-1:0]           addr_out_q, addr_out_d;
    logic                    addr_valid_q, addr_valid_d;
    logic [R_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, rr_addr_q, rr_addr_d;
    logic                    rd_cs_q, rd_cs_d, rr_cs_q, rr_cs_d;
    logic                    rd_we_q, rd_we_d, rr_we_q, rr_we_d;
    logic                    rd_oe_q, rd_oe_d, rr_oe_q, rr_oe_d;
    logic [DATA_WIDTH-1:0]   rd_wdata_q, rd_wdata_d, rr_wdata_q, rr_wdata_d;
`ifdef RF_SEQ_DEBUG_PORT_EN
    logic                    dbg_valid_q, dbg_valid_d;
    logic [DATA_WIDTH-1:0]   dbg_rdata_q, dbg_rdata_d;
`endif

    logic [PW-1:0] rd_ptr, new_ptr, eff_addr;
    logic          req_legal;

    assign rd_ptr    = {rr_rdata, rd_rdata};
    assign req_legal = (req_ptr != 2'd3) && (req_mode != 2'd3);

    // The adjusted pointer comes straight from the read data so UPDATE outputs can be registered at the READ edge.
    pointer_incdec #(.W(PW)) u_incdec (
        .ptr      (rd_ptr),
        .mode     (mode_q),
        .new_ptr  (new_ptr),
        .eff_addr (eff_addr)
    );

    always_comb begin
        state_d      = state_q;
        ptr_sel_d    = ptr_sel_q;
        mode_d       = mode_q;
        ptr_d        = ptr_q;
        ready_d      = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        addr_out_d   = '0;
        addr_valid_d = 1'b0;
        rd_addr_d    = '0;
        rr_addr_d    = '0;
        rd_cs_d      = 1'b0;
        rr_cs_d      = 1'b0;
        rd_we_d      = 1'b0;
        rr_we_d      = 1'b0;
        rd_oe_d      = 1'b0;
        rr_oe_d      = 1'b0;
        rd_wdata_d   = '0;
        rr_wdata_d   = '0;
`ifdef RF_SEQ_DEBUG_PORT_EN
        dbg_valid_d  = 1'b0;
        dbg_rdata_d  = dbg_rdata_q;
`endif
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (req) begin
                    if (req_legal) begin
                        ptr_sel_d = req_ptr;
                        mode_d    = req_mode;
                        state_d   = ST_READ;
                        ready_d   = 1'b0;
                        rd_addr_d = R_ADDR_WIDTH'(lo_reg(req_ptr));
                        rr_addr_d = R_ADDR_WIDTH'(lo_reg(req_ptr) + 1);
                        rd_cs_d   = 1'b1;
                        rr_cs_d   = 1'b1;
                        rd_oe_d   = 1'b1;
                        rr_oe_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
`ifdef RF_SEQ_DEBUG_PORT_EN
                else if (dbg_req) begin
                    state_d   = ST_DBG;
                    ready_d   = 1'b0;
                    rd_addr_d = dbg_addr;
                    rd_cs_d   = 1'b1;
                    rd_oe_d   = 1'b1;
                end
`endif
            end
            ST_READ: begin
                ptr_d        = rd_ptr;
                state_d      = ST_UPDATE;
                done_d       = 1'b1;
                addr_valid_d = 1'b1;
                addr_out_d   = eff_addr;
                if (mode_q != MODE_PLAIN) begin
                    rd_addr_d  = R_ADDR_WIDTH'(lo_reg(ptr_sel_q));
                    rr_addr_d  = R_ADDR_WIDTH'(lo_reg(ptr_sel_q) + 1);
                    rd_cs_d    = 1'b1;
                    rr_cs_d    = 1'b1;
                    rd_we_d    = 1'b1;
                    rr_we_d    = 1'b1;
                    rd_wdata_d = new_ptr[DATA_WIDTH-1:0];
                    rr_wdata_d = new_ptr[PW-1:DATA_WIDTH];
                end
            end
`ifdef RF_SEQ_DEBUG_PORT_EN
            ST_DBG: begin
                state_d     = ST_IDLE;
                ready_d     = 1'b1;
                dbg_valid_d = 1'b1;
                dbg_rdata_d = rd_rdata;
            end
`endif
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ptr_sel_q    <= PTR_X;
            mode_q       <= MODE_PLAIN;
            ptr_q        <= '0;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            addr_out_q   <= '0;
            addr_valid_q <= 1'b0;
            rd_addr_q    <= '0;
            rr_addr_q    <= '0;
            rd_cs_q      <= 1'b0;
            rr_cs_q      <= 1'b0;
            rd_we_q      <= 1'b0;
            rr_we_q      <= 1'b0;
            rd_oe_q      <= 1'b0;
            rr_oe_q      <= 1'b0;
            rd_wdata_q   <= '0;
            rr_wdata_q   <= '0;
`ifdef RF_SEQ_DEBUG_PORT_EN
            dbg_valid_q  <= 1'b0;
            dbg_rdata_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_sel_q    <= ptr_sel_d;
            mode_q       <= mode_d;
            ptr_q        <= ptr_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            err_q        <= err_d;
            addr_out_q   <= addr_out_d;
            addr_valid_q <= addr_valid_d;
            rd_addr_q    <= rd_addr_d;
            rr_addr_q    <= rr_addr_d;
            rd_cs_q      <= rd_cs_d;
            rr_cs_q      <= rr_cs_d;
            rd_we_q      <= rd_we_d;
            rr_we_q      <= rr_we_d;
            rd_oe_q      <= rd_oe_d;
            rr_oe_q      <= rr_oe_d;
            rd_wdata_q   <= rd_wdata_d;
            rr_wdata_q   <= rr_wdata_d;
`ifdef RF_SEQ_DEBUG_PORT_EN
            dbg_valid_q  <= dbg_valid_d;
            dbg_rdata_q  <= dbg_rdata_d;
`endif
        end
    end

    assign ready      = ready_q;
    assign done       = done_q;
    assign err        = err_q;
    assign addr_out   = addr_out_q;
    assign addr_valid = addr_valid_q;
    assign rd_addr    = rd_addr_q;
    assign rr_addr    = rr_addr_q;
    assign rd_cs      = rd_cs_q;
    assign rr_cs      = rr_cs_q;
    assign rd_we      = rd_we_q;
    assign rr_we      = rr_we_q;
    assign rd_oe      = rd_oe_q;
    assign rr_oe      = rr_oe_q;
    assign rd_wdata   = rd_wdata_q;
    assign rr_wdata   = rr_wdata_q;
`ifdef RF_SEQ_DEBUG_PORT_EN
    assign dbg_valid  = dbg_valid_q;
    assign dbg_rdata  = dbg_rdata_q;
`endif

endmodule
